// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, one-cycle-latency imem reads, 2-entry
// word queue to decode with valid/ready, and branch redirect flush.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_addr, imem_rd       fetch address (= pc) and read strobe
//   imem_data                word returned the cycle after imem_rd
//   ir_out, pc_out, ir_valid head of queue (zeros when empty)
//   ir_ready                 decode consumes head on ir_valid & ir_ready
//   br_taken, br_target      redirect request, target forced word aligned
`timescale 1ns/1ps

module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_rd,
    input  logic [31:0] imem_data,
    output logic [31:0] ir_out,
    output logic [31:0] pc_out,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        br_taken,
    input  logic [31:0] br_target
);

    logic [31:0] pc;
    logic [31:0] inflight_pc;
    logic        inflight;

    logic [31:0] q_instr [2];
    logic [31:0] q_pc    [2];
    logic        head;
    logic        tail;
    logic [1:0]  count;

    logic        deq;
    logic        issue;
    logic        push;
    logic [2:0]  occ;
    logic [2:0]  limit;
    logic [31:0] br_pc;

    assign ir_valid = (count != 2'd0);
    assign deq      = ir_valid & ir_ready;

    // Occupancy after this cycle's consume must leave room for one more
    // response, so the in-flight word can never land on a full queue.
    assign occ   = {1'b0, count} + {2'b00, inflight};
    assign limit = 3'd1 + {2'b00, deq};
    assign issue = !rst & !br_taken & (occ <= limit);

    assign push  = inflight & !br_taken;
    assign br_pc = br_target & 32'hFFFF_FFFC;

    assign imem_rd   = issue;
    assign imem_addr = pc;
    assign ir_out    = ir_valid ? q_instr[head] : 32'h0;
    assign pc_out    = ir_valid ? q_pc[head]    : 32'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
            count       <= 2'd0;
            head        <= 1'b0;
            tail        <= 1'b0;
        end else if (br_taken) begin
            pc          <= br_pc;
            inflight    <= 1'b0;
            count       <= 2'd0;
            head        <= 1'b0;
            tail        <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end
            if (push)
                tail <= ~tail;
            if (deq)
                head <= ~head;
            count <= count + {1'b0, push} - {1'b0, deq};
        end
    end

    // Payload storage needs no reset: outputs are masked by ir_valid.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            q_instr[tail] <= imem_data;
            q_pc[tail]    <= inflight_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(push && count == 2'd2));
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: sync memory model, scoreboard of expected
// fetch addresses, directed stall / redirect / wrap / reset cases.
`timescale 1ns/1ps

module tb_instr_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic        imem_rd;
    logic [31:0] imem_data = 32'h0;
    logic [31:0] ir_out;
    logic [31:0] pc_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        br_taken;
    logic [31:0] br_target;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sb [$];
    logic [31:0] sb_e;
    logic [31:0] hold_ir;
    logic [31:0] hold_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC)) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_rd   (imem_rd),
        .imem_data (imem_data),
        .ir_out    (ir_out),
        .pc_out    (pc_out),
        .ir_valid  (ir_valid),
        .ir_ready  (ir_ready),
        .br_taken  (br_taken),
        .br_target (br_target)
    );

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hE000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sb_load(input logic [31:0] start);
        sb.delete();
        for (int i = 0; i < 64; i++)
            sb.push_back(start + 32'(i * 4));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Synchronous instruction memory, one-cycle read latency.
    always @(posedge clk)
        imem_data <= imem_rd ? word(imem_addr) : 32'hBADB_AD00;

    // Scoreboard: reset/redirect load the expected address stream,
    // every handshake pops and compares the head.
    always @(negedge clk) begin
        if (rst) begin
            sb_load(RPC);
        end else begin
            if (ir_valid && ir_ready) begin
                if (sb.size() == 0) begin
                    check("sb_empty", 32'(sb.size()), 32'd1);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_pc", pc_out, sb_e);
                    check("sb_ir", ir_out, word(sb_e));
                end
            end
            if (br_taken)
                sb_load(br_target & 32'hFFFF_FFFC);
        end
    end

    initial begin
        rst       = 1'b1;
        ir_ready  = 1'b1;
        br_taken  = 1'b0;
        br_target = 32'h0;
        step();
        step();
        check("rst_rd", 32'(imem_rd), 32'd0);
        check("rst_valid", 32'(ir_valid), 32'd0);
        check("rst_ir", ir_out, 32'h0);
        check("rst_pcout", pc_out, 32'h0);

        // cycle 0 issues RESET_PC, ir_valid in cycle 2
        rst = 1'b0;
        #1;
        check("c0_rd", 32'(imem_rd), 32'd1);
        check("c0_addr", imem_addr, RPC);
        step();
        check("c1_valid", 32'(ir_valid), 32'd0);
        step();
        check("c2_valid", 32'(ir_valid), 32'd1);
        check("c2_pc", pc_out, RPC);
        repeat (6) step();

        // stall for 5 cycles
        ir_ready = 1'b0;
        #1;
        hold_ir = ir_out;
        hold_pc = pc_out;
        for (int i = 0; i < 5; i++) begin
            check("stall_rd", 32'(imem_rd), 32'd0);
            check("stall_ir", ir_out, hold_ir);
            check("stall_pc", pc_out, hold_pc);
            step();
        end
        check("stall_valid", 32'(ir_valid), 32'd1);

        // release: issue resumes the same cycle, no bubble
        ir_ready = 1'b1;
        #1;
        check("rel_rd", 32'(imem_rd), 32'd1);
        for (int i = 0; i < 4; i++) begin
            step();
            check("rel_valid", 32'(ir_valid), 32'd1);
        end

        // redirect with a full queue
        ir_ready = 1'b0;
        step();
        br_taken  = 1'b1;
        br_target = 32'h0000_0103;
        #1;
        check("br1_rd", 32'(imem_rd), 32'd0);
        step();
        br_taken = 1'b0;
        ir_ready = 1'b1;
        #1;
        check("br1_t1_rd", 32'(imem_rd), 32'd1);
        check("br1_t1_addr", imem_addr, 32'h0000_0100);
        check("br1_t1_valid", 32'(ir_valid), 32'd0);
        step();
        check("br1_t2_valid", 32'(ir_valid), 32'd0);
        step();
        check("br1_t3_valid", 32'(ir_valid), 32'd1);
        check("br1_t3_pc", pc_out, 32'h0000_0100);
        repeat (4) step();

        // redirect coinciding with a consume and a response arrival
        br_taken  = 1'b1;
        br_target = 32'h0000_0200;
        #1;
        check("br2_rd", 32'(imem_rd), 32'd0);
        check("br2_valid", 32'(ir_valid), 32'd1);
        step();
        br_taken = 1'b0;
        #1;
        check("br2_t1_valid", 32'(ir_valid), 32'd0);
        step();
        check("br2_t2_valid", 32'(ir_valid), 32'd0);
        step();
        check("br2_t3_pc", pc_out, 32'h0000_0200);
        repeat (3) step();

        // PC wraparound
        br_taken  = 1'b1;
        br_target = 32'hFFFF_FFF8;
        step();
        br_taken = 1'b0;
        step();
        step();
        check("wrap_pc0", pc_out, 32'hFFFF_FFF8);
        step();
        check("wrap_pc1", pc_out, 32'hFFFF_FFFC);
        step();
        check("wrap_pc2", pc_out, 32'h0000_0000);
        repeat (3) step();

        // reset mid-stream with a full queue
        ir_ready = 1'b0;
        step();
        rst = 1'b1;
        #1;
        check("mrst_rd", 32'(imem_rd), 32'd0);
        step();
        rst      = 1'b0;
        ir_ready = 1'b1;
        #1;
        check("mrst_valid", 32'(ir_valid), 32'd0);
        check("mrst_ir", ir_out, 32'h0);
        check("mrst_addr", imem_addr, RPC);
        check("mrst_rd1", 32'(imem_rd), 32'd1);
        step();
        check("mrst_c1_valid", 32'(ir_valid), 32'd0);
        step();
        check("mrst_c2_valid", 32'(ir_valid), 32'd1);
        check("mrst_c2_pc", pc_out, RPC);
        repeat (4) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
